dma_fifo: RTL and testbench
===========================

# dma_fifo

Longword FIFO datapath and occupancy tracker between the CPU bus state machine (longword/word side) and the SCSI byte state machine (byte side) of the DMA controller. It holds eight 32-bit entries and keeps the next-in (NI) and next-out (NO) entry pointers, the fill count and the byte offset (BO). It produces FIFOEMPTY, FIFOFULL, BOEQ0 and BOEQ3, which the CPU state machine consumes. All pointer and count movement is commanded by strobes from the two state machines; this block makes no transfer decisions.

## Interface
- DEPTH, 8: entries; power of two.
- PTRW, 3: log2(DEPTH).
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- CLRFIFO  in  1  synchronous flush: clears pointers, count, BO and ERR; storage contents are untouched.
- DMADIR  in  1  1 = memory→SCSI (SCSI reads bytes at NO); 0 = SCSI→memory (SCSI writes bytes at NI).
- INCFIFO / DECFIFO  in  1  fill count +1 / −1.
- INCNI / INCNO  in  1  advance NI / NO pointer, modulo DEPTH.
- INCBO  in  1  advance byte offset, modulo 4.
- DIN  in  32  CPU-side write data to entry NI.
- WEH / WEL  in  1  write DIN[31:16] / DIN[15:0] into entry NI.
- SWR  in  1  SCSI byte write of SDIN into entry NI at lane BO (honoured only when DMADIR=0).
- SDIN  in  8  SCSI byte write data.
- DOUT  out  32  entry NO contents (combinational from registered state).
- SDOUT  out  8  byte lane BO of entry NO (combinational).
- FIFOEMPTY / FIFOFULL  out  1  registered; count==0 / count==DEPTH.
- BOEQ0 / BOEQ3  out  1  registered; BO==0 / BO==3.
- NI / NO  out  PTRW  current pointers.
- BO  out  2  current byte offset.
- ERR  out  1  sticky underflow/overflow flag.

## Operation
- Reset values: NI=0, NO=0, count=0, BO=0, ERR=0, FIFOEMPTY=1, FIFOFULL=0, BOEQ0=1, BOEQ3=0. RESET has priority over CLRFIFO, which has priority over all strobes.
- Count is PTRW+1 bits, range 0..DEPTH.
  - INCFIFO&DECFIFO in the same cycle: count unchanged, no error.
  - INCFIFO alone at count==DEPTH: count held, ERR set.
  - DECFIFO alone at count==0: count held, ERR set.
- INCNI and INCNO are independent and may coincide. Pointers wrap from DEPTH−1 to 0. Pointers are not checked against count; consistency is the state machines' responsibility.
- Byte lanes are big-endian: BO=0 maps to bits 31:24 and BO=3 to bits 7:0.
- Storage writes:
  - WEH and WEL may assert together (full longword).
  - SWR with DMADIR=1 is ignored.
  - SWR and WEH/WEL in the same cycle: CPU write wins on overlapping lanes.
- A write and an INCNI in the same cycle write the old NI entry.
- INCBO wraps 3→0. It is independent of INCNI; the SCSI state machine issues INCNI+INCFIFO (or INCNO+DECFIFO) alongside the INCBO that wraps.
- ERR clears only on RESET or CLRFIFO.

## Timing
- Strobes sampled at edge N; NI/NO/BO/count/flags reflect them after edge N.
- Flags are registered and computed from next-state values, so they are valid in the same cycle the count changes: no extra cycle of lag.
- DOUT/SDOUT are valid combinationally after any edge that changes NO, BO or entry NO.
- Write-to-read of the same entry: data appears on DOUT the cycle after the write edge.
- Sequence count 7 + INCFIFO → FIFOFULL=1 after that edge. Next cycle DECFIFO → FIFOFULL=0 after the edge.

## Structure
- Shared package holds: DEPTH/PTRW defaults; the byte-lane constants (LANE0_HI=31 … LANE3_LO=0); the DMADIR encoding constants.
- One natural sub-module, dma_fifo_ram: DEPTH×32 storage with four per-byte write enables and an asynchronous read port.
- Pointer, count, BO and flag logic stays in dma_fifo.

## Test plan
- Reset/flush:
  - RESET for 1 cycle → FIFOEMPTY=1, BOEQ0=1, NI=NO=BO=0, ERR=0.
  - Mid-fill (count=5) CLRFIFO → same values on the next cycle.
- CPU fill/drain:
  - 8× (WEH,WEL,DIN=0x1000_0000+i, INCNI, INCFIFO) → FIFOFULL=1, NI=0.
  - Then 8× (INCNO, DECFIFO) → DOUT sequence 0x1000_0000..0x1000_0007, FIFOEMPTY=1.
- SCSI byte packing:
  - DMADIR=0, bytes 0xDE,0xAD,0xBE,0xEF with SWR+INCBO, INCNI+INCFIFO on the 4th → entry0=0xDEADBEEF.
  - BOEQ3=1 after the 3rd byte; BO=0 and count=1 after the 4th.
- SCSI unpack:
  - DMADIR=1, entry NO=0x01234567, four INCBO → SDOUT 0x01,0x23,0x45,0x67.
  - SWR during this sequence leaves the entry unchanged.
- Boundaries:
  - INCFIFO at count=8 → count stays 8, ERR=1.
  - DECFIFO at count=0 → ERR=1.
  - INCFIFO+DECFIFO at count=8 → count 8, ERR unchanged.
- Wrap and collision:
  - NI=7, WEH+WEL+INCNI → entry7 written, NI=0.
  - Simultaneous SWR (BO=0, 0xAA) and WEH (DIN[31:16]=0x5555) → entry bits 31:24=0x55.

Source files
------------

// File: rtl/dma_fifo_pkg.sv
// dma_fifo_pkg
// Shared definitions for the DMA longword FIFO: default geometry, the
// big-endian byte-lane bit positions, the DMADIR encoding and small helpers
// that map a byte offset onto a lane.
package dma_fifo_pkg;

  localparam int DEPTH_DEFAULT = 8;
  localparam int PTRW_DEFAULT  = 3;

  // Byte offset 0 is the most significant byte of the longword.
  localparam int LANE0_HI = 31;
  localparam int LANE0_LO = 24;
  localparam int LANE1_HI = 23;
  localparam int LANE1_LO = 16;
  localparam int LANE2_HI = 15;
  localparam int LANE2_LO = 8;
  localparam int LANE3_HI = 7;
  localparam int LANE3_LO = 0;

  localparam logic DIR_SCSI_TO_MEM = 1'b0;
  localparam logic DIR_MEM_TO_SCSI = 1'b1;

  // Byte-enable vector for a byte offset; enable bit i covers bits 8i+7:8i,
  // so offset 0 lands on enable bit 3.
  function automatic logic [3:0] lane_enable(input logic [1:0] bo);
    logic [3:0] be;
    case (bo)
      2'd0:    be = 4'b1000;
      2'd1:    be = 4'b0100;
      2'd2:    be = 4'b0010;
      default: be = 4'b0001;
    endcase
    return be;
  endfunction

  // Extract the byte selected by a byte offset from a longword.
  function automatic logic [7:0] lane_byte(input logic [31:0] word,
                                           input logic [1:0]  bo);
    logic [7:0] b;
    case (bo)
      2'd0:    b = word[LANE0_HI:LANE0_LO];
      2'd1:    b = word[LANE1_HI:LANE1_LO];
      2'd2:    b = word[LANE2_HI:LANE2_LO];
      default: b = word[LANE3_HI:LANE3_LO];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dma_fifo_ram.sv
// dma_fifo_ram
// DEPTH x 32 storage for the DMA FIFO with per-byte write enables and an
// asynchronous read port. Contents are never reset.
// Ports:
//   CLK      system clock, writes on rising edge
//   wr_addr  entry written
//   wr_data  write data (all four lanes, qualified by wr_be)
//   wr_be    per-byte write enables, bit i covers wr_data[8i+7:8i]
//   rd_addr  entry read
//   rd_data  contents of entry rd_addr (combinational)
module dma_fifo_ram
  import dma_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int PTRW  = PTRW_DEFAULT
) (
  input  logic            CLK,
  input  logic [PTRW-1:0] wr_addr,
  input  logic [31:0]     wr_data,
  input  logic [3:0]      wr_be,
  input  logic [PTRW-1:0] rd_addr,
  output logic [31:0]     rd_data
);

  logic [31:0] mem [DEPTH];

  // Byte-granular write so CPU word halves and SCSI bytes can share an entry.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_be[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dma_fifo.sv
// dma_fifo
// Longword FIFO between the CPU bus state machine and the SCSI byte state
// machine. Tracks NI/NO pointers, fill count and byte offset, and produces
// registered status flags. All movement is commanded by strobes.
// Ports:
//   CLK, RESET          clock and synchronous active-high reset
//   CLRFIFO             flush pointers, count, BO and ERR (storage kept)
//   DMADIR              1 = memory to SCSI, 0 = SCSI to memory
//   INCFIFO, DECFIFO    fill count +1 / -1
//   INCNI, INCNO        advance NI / NO
//   INCBO               advance byte offset
//   DIN, WEH, WEL       CPU write of upper / lower halfword into entry NI
//   SWR, SDIN           SCSI byte write into entry NI at lane BO
//   DOUT, SDOUT         entry NO and its lane BO
//   FIFOEMPTY, FIFOFULL registered count==0 / count==DEPTH
//   BOEQ0, BOEQ3        registered BO==0 / BO==3
//   NI, NO, BO          current pointers and byte offset
//   ERR                 sticky overflow/underflow
module dma_fifo
  import dma_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int PTRW  = PTRW_DEFAULT
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            CLRFIFO,
  input  logic            DMADIR,
  input  logic            INCFIFO,
  input  logic            DECFIFO,
  input  logic            INCNI,
  input  logic            INCNO,
  input  logic            INCBO,
  input  logic [31:0]     DIN,
  input  logic            WEH,
  input  logic            WEL,
  input  logic            SWR,
  input  logic [7:0]      SDIN,
  output logic [31:0]     DOUT,
  output logic [7:0]      SDOUT,
  output logic            FIFOEMPTY,
  output logic            FIFOFULL,
  output logic            BOEQ0,
  output logic            BOEQ3,
  output logic [PTRW-1:0] NI,
  output logic [PTRW-1:0] NO,
  output logic [1:0]      BO,
  output logic            ERR
);

  localparam logic [PTRW:0]   CNT_FULL = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0]   CNT_ONE  = (PTRW+1)'(1);
  localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);

  logic [PTRW:0]   count_q, count_d;
  logic [PTRW-1:0] ni_q, ni_d, no_q, no_d;
  logic [1:0]      bo_q, bo_d;
  logic            err_q, err_d;
  logic            empty_q, full_q, boeq0_q, boeq3_q;

  logic [3:0]      cpu_be, scsi_be, ram_be;
  logic [31:0]     ram_wdata;

  // Next-state for pointers, count, byte offset and the sticky error.
  // A flush overrides every strobe; a simultaneous inc/dec is a no-op.
  always_comb begin
    ni_d    = ni_q;
    no_d    = no_q;
    bo_d    = bo_q;
    count_d = count_q;
    err_d   = err_q;
    if (CLRFIFO) begin
      ni_d    = '0;
      no_d    = '0;
      bo_d    = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (INCNI) ni_d = ni_q + PTR_ONE;
      if (INCNO) no_d = no_q + PTR_ONE;
      if (INCBO) bo_d = bo_q + 2'd1;
      case ({INCFIFO, DECFIFO})
        2'b10: begin
          if (count_q == CNT_FULL) err_d = 1'b1;
          else                     count_d = count_q + CNT_ONE;
        end
        2'b01: begin
          if (count_q == '0) err_d = 1'b1;
          else               count_d = count_q - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  // State registers; flags are derived from next-state values so they line
  // up with the count/BO they describe.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ni_q    <= '0;
      no_q    <= '0;
      bo_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      boeq0_q <= 1'b1;
      boeq3_q <= 1'b0;
    end else begin
      ni_q    <= ni_d;
      no_q    <= no_d;
      bo_q    <= bo_d;
      count_q <= count_d;
      err_q   <= err_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_FULL);
      boeq0_q <= (bo_d == 2'd0);
      boeq3_q <= (bo_d == 2'd3);
    end
  end

  // Storage write merge: CPU halfwords win over the SCSI byte on shared
  // lanes. SCSI writes only count when bytes flow into memory. Reset and
  // flush suppress all writes since they outrank every strobe.
  always_comb begin
    cpu_be  = {WEH, WEH, WEL, WEL};
    scsi_be = (SWR && (DMADIR == DIR_SCSI_TO_MEM)) ? lane_enable(bo_q) : 4'b0000;
    ram_be  = (RESET || CLRFIFO) ? 4'b0000 : (cpu_be | scsi_be);
    ram_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      ram_wdata[i*8 +: 8] = cpu_be[i] ? DIN[i*8 +: 8] : SDIN;
    end
  end

  dma_fifo_ram #(
    .DEPTH (DEPTH),
    .PTRW  (PTRW)
  ) u_ram (
    .CLK     (CLK),
    .wr_addr (ni_q),
    .wr_data (ram_wdata),
    .wr_be   (ram_be),
    .rd_addr (no_q),
    .rd_data (DOUT)
  );

  assign SDOUT     = lane_byte(DOUT, bo_q);
  assign FIFOEMPTY = empty_q;
  assign FIFOFULL  = full_q;
  assign BOEQ0     = boeq0_q;
  assign BOEQ3     = boeq3_q;
  assign NI        = ni_q;
  assign NO        = no_q;
  assign BO        = bo_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_dma_fifo.sv
// tb_dma_fifo
// Directed bench for dma_fifo: reset/flush, CPU fill and drain, SCSI byte
// pack and unpack, count boundaries, pointer wrap and write collision.
module tb_dma_fifo;

  logic        CLK;
  logic        RESET, CLRFIFO, DMADIR;
  logic        INCFIFO, DECFIFO, INCNI, INCNO, INCBO;
  logic [31:0] DIN;
  logic        WEH, WEL, SWR;
  logic [7:0]  SDIN;
  logic [31:0] DOUT;
  logic [7:0]  SDOUT;
  logic        FIFOEMPTY, FIFOFULL, BOEQ0, BOEQ3;
  logic [2:0]  NI, NO;
  logic [1:0]  BO;
  logic        ERR;

  int tests_run = 0;
  int tests_failed = 0;

  dma_fifo dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .CLRFIFO   (CLRFIFO),
    .DMADIR    (DMADIR),
    .INCFIFO   (INCFIFO),
    .DECFIFO   (DECFIFO),
    .INCNI     (INCNI),
    .INCNO     (INCNO),
    .INCBO     (INCBO),
    .DIN       (DIN),
    .WEH       (WEH),
    .WEL       (WEL),
    .SWR       (SWR),
    .SDIN      (SDIN),
    .DOUT      (DOUT),
    .SDOUT     (SDOUT),
    .FIFOEMPTY (FIFOEMPTY),
    .FIFOFULL  (FIFOFULL),
    .BOEQ0     (BOEQ0),
    .BOEQ3     (BOEQ3),
    .NI        (NI),
    .NO        (NO),
    .BO        (BO),
    .ERR       (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Apply whatever strobes are set up across one rising edge, then drop
  // all single-cycle strobes. Outputs are stable 1 time unit after the edge.
  task automatic apply_stimulus();
    @(posedge CLK);
    #1;
    RESET   = 1'b0;
    CLRFIFO = 1'b0;
    INCFIFO = 1'b0;
    DECFIFO = 1'b0;
    INCNI   = 1'b0;
    INCNO   = 1'b0;
    INCBO   = 1'b0;
    WEH     = 1'b0;
    WEL     = 1'b0;
    SWR     = 1'b0;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] unpack_exp [4];
    unpack_exp[0] = 8'h23;
    unpack_exp[1] = 8'h45;
    unpack_exp[2] = 8'h67;
    unpack_exp[3] = 8'h01;

    RESET = 1'b1; CLRFIFO = 1'b0; DMADIR = 1'b0;
    INCFIFO = 1'b0; DECFIFO = 1'b0; INCNI = 1'b0; INCNO = 1'b0; INCBO = 1'b0;
    DIN = '0; WEH = 1'b0; WEL = 1'b0; SWR = 1'b0; SDIN = '0;

    // Reset
    #2;
    RESET = 1'b1;
    apply_stimulus();
    check_output("rst_empty", 32'(FIFOEMPTY), 32'd1);
    check_output("rst_full",  32'(FIFOFULL),  32'd0);
    check_output("rst_boeq0", 32'(BOEQ0),     32'd1);
    check_output("rst_boeq3", 32'(BOEQ3),     32'd0);
    check_output("rst_ni",    32'(NI),        32'd0);
    check_output("rst_no",    32'(NO),        32'd0);
    check_output("rst_bo",    32'(BO),        32'd0);
    check_output("rst_err",   32'(ERR),       32'd0);

    // CPU fill of all eight entries
    for (int i = 0; i < 8; i++) begin
      WEH = 1'b1; WEL = 1'b1; DIN = 32'h1000_0000 + 32'(i);
      INCNI = 1'b1; INCFIFO = 1'b1;
      apply_stimulus();
      if (i == 6) check_output("fill7_full", 32'(FIFOFULL), 32'd0);
    end
    check_output("fill_full",  32'(FIFOFULL),  32'd1);
    check_output("fill_empty", 32'(FIFOEMPTY), 32'd0);
    check_output("fill_ni",    32'(NI),        32'd0);

    // Inc+dec at full is a no-op without error
    INCFIFO = 1'b1; DECFIFO = 1'b1;
    apply_stimulus();
    check_output("incdec_full", 32'(FIFOFULL), 32'd1);
    check_output("incdec_err",  32'(ERR),      32'd0);

    // Drain
    for (int i = 0; i < 8; i++) begin
      check_output("drain_dout", DOUT, 32'h1000_0000 + 32'(i));
      INCNO = 1'b1; DECFIFO = 1'b1;
      apply_stimulus();
      if (i == 0) check_output("drain1_full", 32'(FIFOFULL), 32'd0);
    end
    check_output("drain_empty", 32'(FIFOEMPTY), 32'd1);
    check_output("drain_no",    32'(NO),        32'd0);

    // Underflow
    DECFIFO = 1'b1;
    apply_stimulus();
    check_output("under_err",   32'(ERR),       32'd1);
    check_output("under_empty", 32'(FIFOEMPTY), 32'd1);
    CLRFIFO = 1'b1;
    apply_stimulus();
    check_output("clr_err", 32'(ERR), 32'd0);

    // Overflow
    for (int i = 0; i < 8; i++) begin
      INCFIFO = 1'b1;
      apply_stimulus();
    end
    check_output("ovf_pre_err", 32'(ERR), 32'd0);
    INCFIFO = 1'b1;
    apply_stimulus();
    check_output("ovf_err",  32'(ERR),      32'd1);
    check_output("ovf_full", 32'(FIFOFULL), 32'd1);
    CLRFIFO = 1'b1;
    apply_stimulus();
    check_output("ovfclr_full", 32'(FIFOFULL), 32'd0);

    // Mid-fill flush at count 5
    for (int i = 0; i < 5; i++) begin
      INCFIFO = 1'b1; INCNI = 1'b1; INCNO = (i < 2); INCBO = (i < 2);
      apply_stimulus();
    end
    check_output("mid_ni",    32'(NI),        32'd5);
    check_output("mid_bo",    32'(BO),        32'd2);
    check_output("mid_empty", 32'(FIFOEMPTY), 32'd0);
    CLRFIFO = 1'b1; INCFIFO = 1'b1; INCBO = 1'b1;
    apply_stimulus();
    check_output("flush_empty", 32'(FIFOEMPTY), 32'd1);
    check_output("flush_ni",    32'(NI),        32'd0);
    check_output("flush_no",    32'(NO),        32'd0);
    check_output("flush_bo",    32'(BO),        32'd0);
    check_output("flush_boeq0", 32'(BOEQ0),     32'd1);
    check_output("flush_err",   32'(ERR),       32'd0);

    // SCSI byte packing into entry 0
    DMADIR = 1'b0;
    SWR = 1'b1; SDIN = 8'hDE; INCBO = 1'b1;
    apply_stimulus();
    SWR = 1'b1; SDIN = 8'hAD; INCBO = 1'b1;
    apply_stimulus();
    SWR = 1'b1; SDIN = 8'hBE; INCBO = 1'b1;
    apply_stimulus();
    check_output("pack3_boeq3", 32'(BOEQ3), 32'd1);
    check_output("pack3_bo",    32'(BO),    32'd3);
    SWR = 1'b1; SDIN = 8'hEF; INCBO = 1'b1; INCNI = 1'b1; INCFIFO = 1'b1;
    apply_stimulus();
    check_output("pack4_bo",    32'(BO),        32'd0);
    check_output("pack4_boeq0", 32'(BOEQ0),     32'd1);
    check_output("pack4_boeq3", 32'(BOEQ3),     32'd0);
    check_output("pack4_ni",    32'(NI),        32'd1);
    check_output("pack4_empty", 32'(FIFOEMPTY), 32'd0);
    check_output("pack_dout",   DOUT,           32'hDEAD_BEEF);
    check_output("pack_sdout",  32'(SDOUT),     32'hDE);
    INCNO = 1'b1; DECFIFO = 1'b1;
    apply_stimulus();
    check_output("pack_cnt1_empty", 32'(FIFOEMPTY), 32'd1);
    check_output("pack_cnt1_err",   32'(ERR),       32'd0);

    // SCSI unpack of entry 1; SWR must be ignored in this direction
    WEH = 1'b1; WEL = 1'b1; DIN = 32'h0123_4567; INCNI = 1'b1; INCFIFO = 1'b1;
    apply_stimulus();
    DMADIR = 1'b1;
    check_output("unpack_dout0", DOUT,        32'h0123_4567);
    check_output("unpack_b0",    32'(SDOUT),  32'h01);
    for (int k = 0; k < 4; k++) begin
      SWR = 1'b1; SDIN = 8'hFF; INCBO = 1'b1;
      apply_stimulus();
      check_output("unpack_sdout", 32'(SDOUT), 32'(unpack_exp[k]));
    end
    check_output("unpack_entry", DOUT, 32'h0123_4567);
    INCNO = 1'b1; DECFIFO = 1'b1;
    apply_stimulus();
    check_output("unpack_no", 32'(NO), 32'd2);

    // NI wrap with a full longword write into entry 7
    for (int i = 0; i < 5; i++) begin
      INCNI = 1'b1;
      apply_stimulus();
    end
    check_output("wrap_ni7", 32'(NI), 32'd7);
    WEH = 1'b1; WEL = 1'b1; DIN = 32'hCAFE_F00D; INCNI = 1'b1;
    apply_stimulus();
    check_output("wrap_ni0", 32'(NI), 32'd0);
    for (int i = 0; i < 5; i++) begin
      INCNO = 1'b1;
      apply_stimulus();
    end
    check_output("wrap_no7",   32'(NO), 32'd7);
    check_output("wrap_entry", DOUT,    32'hCAFE_F00D);
    INCNO = 1'b1;
    apply_stimulus();
    check_output("wrap_no0", 32'(NO), 32'd0);
    check_output("entry0",   DOUT,    32'hDEAD_BEEF);

    // Collision: SCSI byte at lane 0 against CPU upper halfword
    DMADIR = 1'b0;
    SWR = 1'b1; SDIN = 8'hAA; WEH = 1'b1; DIN = 32'h5555_1234;
    apply_stimulus();
    check_output("coll_dout",  DOUT,       32'h5555_BEEF);
    check_output("coll_sdout", 32'(SDOUT), 32'h55);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
